// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART TX scheduler.
// State enum, frame length in bits, clocks-per-bit helper.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FRAME = 2'd2
  } state_t;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  function automatic int clks_per_bit(
    input int freq,
    input int baud
  );
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request after i_ptr wins.
// Ports: i_req, i_ptr in; o_gnt one-hot, o_idx, o_any out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    // k = N revisits the pointer itself last
    for (int k = 1; k <= N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between N_REQ producers, one frame per grant.
// Ports: clk, rst_n, req_valid/req_data/req_ready, tx_start, tx_data, busy,
// grant_id. Define UART_TX_SCHED_PRIO_EN to give requester 0 fixed priority.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int GAP_BITS    = 1,
  localparam int IW         = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic [IW-1:0]      grant_id
);

  localparam int CPB     = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int F_CLKS  = (FRAME_BITS + GAP_BITS) * CPB;
  localparam int CW      = $clog2(F_CLKS);
  localparam logic [CW-1:0] CNT_INIT = CW'(F_CLKS - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_ptr;
  logic [7:0]      r_data;
  logic [IW-1:0]   r_gid;

  logic [N_REQ-1:0] w_req_rr;
  logic [N_REQ-1:0] w_gnt_rr;
  logic [IW-1:0]    w_idx_rr;
  logic             w_any_rr;
  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic             w_hs;

`ifdef UART_TX_SCHED_PRIO_EN
  // requester 0 bypasses the ring; the ring only covers 1..N_REQ-1
  assign w_req_rr = req_valid & ~N_REQ'(1);
  assign w_gnt    = req_valid[0] ? N_REQ'(1) : w_gnt_rr;
  assign w_idx    = req_valid[0] ? '0 : w_idx_rr;
  assign w_any    = req_valid[0] | w_any_rr;
`else
  assign w_req_rr = req_valid;
  assign w_gnt    = w_gnt_rr;
  assign w_idx    = w_idx_rr;
  assign w_any    = w_any_rr;
`endif

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .i_req (w_req_rr),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt_rr),
    .o_idx (w_idx_rr),
    .o_any (w_any_rr)
  );

  // ready is the grant, so a visible winner always handshakes
  assign w_hs = (r_state == IDLE) && w_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = LOAD;
      LOAD:    w_next = FRAME;
      FRAME:   if (r_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    tx_start  = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      IDLE:    begin
        req_ready = w_gnt;
        busy      = 1'b0;
      end
      LOAD:    tx_start = 1'b1;
      FRAME:   ;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_ptr  <= IW'(N_REQ - 1);
      r_data <= 8'h00;
      r_gid  <= '0;
    end else begin
      if (w_hs) begin
        r_data <= req_data[8*w_idx +: 8];
        r_gid  <= w_idx;
`ifdef UART_TX_SCHED_PRIO_EN
        if (w_idx != '0) r_ptr <= w_idx;
`else
        r_ptr  <= w_idx;
`endif
      end
      if (r_state == LOAD)
        r_cnt <= CNT_INIT;
      else if (r_state == FRAME)
        r_cnt <= r_cnt - CW'(1);
    end
  end

  assign tx_data  = r_data;
  assign grant_id = r_gid;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler at 10 clk/bit (110-cycle frame).
// Expected {grant_id, tx_data} pairs are queued and checked on tx_start.
module tb_uart_tx_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          busy;
  logic [1:0]    grant_id;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_start = 0;
  bit have_last  = 0;
  bit gap_en     = 0;
  logic [15:0] sb[$];

  uart_tx_scheduler #(
    .N_REQ       (N),
    .CLK_FREQ_HZ (1_000_000),
    .BAUD        (100_000),
    .GAP_BITS    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int id, input logic [7:0] d);
    sb.push_back({8'(id), d});
  endtask

  always @(negedge clk) begin
    if (tx_start) begin
      chk("start_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        logic [15:0] e;
        e = sb.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e[7:0]));
        chk("grant_id", 32'(grant_id), 32'(e[15:8]));
      end
      if (gap_en && have_last)
        chk("grant_gap", cyc - last_start, 112);
      last_start = cyc;
      have_last  = 1;
    end
  end

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    chk("sb_drain", sb.size(), 0);
  endtask

  initial begin
    int n;
    int bad;

    // 1: reset state, single request
    do_reset();
    @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    step();
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 32'b0001);
    push(0, 8'hA5);
    step();
    req_valid = '0;
    wait_idle(n);
    chk("t1_busy_len", n, 111);
    chk("t1_sb", sb.size(), 0);

    // 2: four held requesters, round-robin from 0
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33);
    push(3, 8'h44); push(0, 8'h11);
    have_last = 0;
    gap_en = 1;
    req_valid = 4'b1111;
    wait_sb();
    req_valid = '0;
    gap_en = 0;
    wait_idle(n);

    // 3: request arriving mid-frame waits for IDLE
    req_data = {8'h00, 8'h88, 8'h77, 8'h00};
    req_valid = 4'b0010;
    #1 chk("t3_ready1", 32'(req_ready), 32'b0010);
    push(1, 8'h77);
    step();
    req_valid = '0;
    repeat (20) step();
    req_valid = 4'b0100;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (req_ready != '0) bad++;
    end
    chk("t3_ready_in_frame", bad, 0);
    chk("t3_ready2_idle", 32'(req_ready), 32'b0100);
    push(2, 8'h88);
    step();
    req_valid = '0;
    wait_idle(n);

    // 4: reset mid-frame
    req_data = {8'h01, 8'h00, 8'h00, 8'h5A};
    req_valid = 4'b0001;
    push(0, 8'h5A);
    step();
    req_valid = '0;
    repeat (51) step();
    rst_n = 1'b0;
    #1;
    chk("t4_tx_start", 32'(tx_start), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_tx_data", 32'(tx_data), 0);
    chk("t4_grant_id", 32'(grant_id), 0);
    step();
    rst_n = 1'b1;
    req_data = {8'hD3, 8'h00, 8'h00, 8'h3C};
    req_valid = 4'b1001;
    #1 chk("t4_ready_after", 32'(req_ready), 32'b0001);
    push(0, 8'h3C);
    step();
    req_valid = '0;
    wait_idle(n);

    // 5: requesters 0 and 3 held
    do_reset();
`ifdef UART_TX_SCHED_PRIO_EN
    push(0, 8'h3C); push(0, 8'h3C); push(0, 8'h3C);
`else
    push(0, 8'h3C); push(3, 8'hD3); push(0, 8'h3C);
`endif
    req_valid = 4'b1001;
    wait_sb();
    req_valid = 4'b1000;
    push(3, 8'hD3);
    wait_sb();
    req_valid = '0;
    wait_idle(n);

    // 6: one-cycle pulse during a frame is not latched
    req_data = {8'h00, 8'h00, 8'hEE, 8'hC3};
    req_valid = 4'b0001;
    push(0, 8'hC3);
    step();
    req_valid = '0;
    repeat (30) step();
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    wait_idle(n);
    repeat (200) @(negedge clk);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_sb", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
